ps2_command_tx: RTL

Host-to-device PS/2 transmitter, the outbound counterpart of the existing PS/2 receive path. It sends one command byte to the keyboard, for example 0xED (set LEDs) to mirror note and octave state, or 0xFF (reset). It runs the inhibit/request-to-send sequence, shifts the frame out on device-generated clock edges, and checks the device ACK. The top level ties its open-drain drive outputs onto the PS2_CLK and PS2_DAT inouts.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_sync.sv | 42 ++++
 rtl/ps2_command_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, error codes and command bytes for the PS/2 host-side blocks.
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    XFER      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6,
    FAIL      = 3'd7
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_XFER_TO  = 2'b10;
  localparam logic [1:0] ERR_NO_ACK   = 2'b11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchroniser chains for PS2_CLK/PS2_DAT plus a registered CLK falling-edge pulse.
`default_nettype none

module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic clk_fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_fall_q;

  // Reset to the idle-high bus level so release of reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      clk_fall_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      clk_fall_q <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_sync_o = clk_sync_q[SYNC_STAGES-1];
  assign dat_sync_o = dat_sync_q[SYNC_STAGES-1];
  assign clk_fall_o = clk_fall_q;

endmodule

`default_nettype wire

// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 command byte transmitter with ACK check.
// Optional macro PS2_TX_RETRY_EN: retry start-timeout / no-ACK failures up to twice.
`default_nettype none

module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000,
  parameter int SYNC_STAGES          = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int CW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES)) + 1;
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic [1:0]    err_q, err_d;
  logic          fail_req;
  logic [1:0]    fail_code;
  logic          clk_sync, dat_sync, clk_fall;
  logic [8:0]    frame_w;
  logic [3:0]    frame_idx_w;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry_q, retry_d;
`endif

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (CLOCK_50),
    .rst_ni     (reset_n),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_dat_i  (ps2_dat_in),
    .clk_sync_o (clk_sync),
    .dat_sync_o (dat_sync),
    .clk_fall_o (clk_fall)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      err_q     <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // One timer serves inhibit, start timeout and transfer timeout; the phases never overlap.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    err_d     = err_q;
    fail_req  = 1'b0;
    fail_code = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (cmd_valid) begin
          data_d   = cmd_data;
          parity_d = ~^cmd_data;
          err_d    = ERR_NONE;
          state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d  = '0;
`endif
        end
      end
      INHIBIT: begin
        if (timer_q == INH_LAST) begin
          state_d   = RTS;
          timer_d   = '0;
          bit_cnt_d = '0;
        end
      end
      RTS: begin
        if (timer_q == START_LAST) begin
          fail_req  = 1'b1;
          fail_code = ERR_START_TO;
        end else if (clk_fall) begin
          state_d   = XFER;
          timer_d   = '0;
          bit_cnt_d = 4'd1;
        end
      end
      XFER: begin
        if (timer_q == XFER_LAST) begin
          fail_req  = 1'b1;
          fail_code = ERR_XFER_TO;
        end else if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd10) state_d = ACK;
        end
      end
      ACK: begin
        if (timer_q == XFER_LAST) begin
          fail_req  = 1'b1;
          fail_code = ERR_XFER_TO;
        end else if (!dat_sync) begin
          state_d = WAIT_IDLE;
        end else begin
          fail_req  = 1'b1;
          fail_code = ERR_NO_ACK;
        end
      end
      WAIT_IDLE: begin
        if (timer_q == XFER_LAST) begin
          fail_req  = 1'b1;
          fail_code = ERR_XFER_TO;
        end else if (clk_sync && dat_sync) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (fail_req) begin
      err_d   = fail_code;
      timer_d = '0;
`ifdef PS2_TX_RETRY_EN
      if (fail_code != ERR_XFER_TO && retry_q != 2'd2) begin
        retry_d = retry_q + 2'd1;
        state_d = INHIBIT;
      end else begin
        state_d = FAIL;
      end
`else
      state_d = FAIL;
`endif
    end
  end

  // Edge k of the frame puts frame bit k-1 on DAT: data LSB first, then parity.
  assign frame_w     = {parity_q, data_q};
  assign frame_idx_w = bit_cnt_q - 4'd1;

  always_comb begin
    ps2_clk_drive_low = 1'b0;
    ps2_dat_drive_low = 1'b0;
    case (state_q)
      INHIBIT: begin
        ps2_clk_drive_low = 1'b1;
        ps2_dat_drive_low = (timer_q == INH_LAST);
      end
      RTS:  ps2_dat_drive_low = 1'b1;
      XFER: begin
        if (bit_cnt_q != 4'd0 && bit_cnt_q <= 4'd9) ps2_dat_drive_low = ~frame_w[frame_idx_w];
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == FAIL);
  assign err_code  = err_q;

endmodule

`default_nettype wire
